// File: rtl/nlab2_sweep_ctrl.sv
// Sweep sequencer for a 3-in/2-out combinational block: steps a/b/c through
// all eight vectors, samples x/y at each dwell end and scores against golden tables.
module nlab2_sweep_ctrl #(
   parameter int unsigned DWELL = 2,
   parameter logic [7:0]  EXP_X = 8'hE8,
   parameter logic [7:0]  EXP_Y = 8'h96
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       x,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic       fail_valid,
   output logic [2:0] fail_idx
);

   localparam int unsigned IDX_W = 3;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned ERR_W = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               fv_q, fv_d;
   logic [IDX_W-1:0]   fidx_q, fidx_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic               miss;

   // idx_q doubles as the registered stimulus; it is zero outside DRIVE
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fv_d    = fv_q;
      fidx_d  = fidx_q;
      miss    = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_DRIVE;
               idx_d   = '0;
               cnt_d   = '0;
               err_d   = '0;
               fv_d    = 1'b0;
               fidx_d  = '0;
            end
         end
         S_DRIVE: begin
            if (cnt_q == CNT_W'(DWELL - 1)) begin
               miss  = (x != EXP_X[idx_q]) || (y != EXP_Y[idx_q]);
               cnt_d = '0;
               if (miss) begin
                  err_d = err_q + ERR_W'(1);
                  if (!fv_q) begin
                     fv_d   = 1'b1;
                     fidx_d = idx_q;
                  end
               end
               if (idx_q == IDX_W'(7)) begin
                  state_d = S_DONE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase

      // abort wins over start and suppresses any sample on this edge
      if (abort) begin
         state_d = S_IDLE;
         idx_d   = '0;
         cnt_d   = '0;
         err_d   = err_q;
         fv_d    = fv_q;
         fidx_d  = fidx_q;
      end

      busy_d = (state_d == S_DRIVE);
      done_d = (state_d == S_DONE);
      pass_d = done_d && (err_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         fv_q    <= 1'b0;
         fidx_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
         fidx_q  <= fidx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign a          = idx_q[2];
   assign b          = idx_q[1];
   assign c          = idx_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_valid = fv_q;
   assign fail_idx   = fidx_q;

endmodule
